// File: rtl/md_pkg.sv
// rtl/md_pkg.sv - shared opcode/state types and iteration constants for the multiply/divide unit
package md_pkg;

  localparam int MD_ITER  = 32;
  localparam int MD_CNT_W = 5;

  typedef enum logic [3:0] {
    MD_MUL    = 4'b1000,
    MD_MULH   = 4'b1001,
    MD_MULHSU = 4'b1010,
    MD_MULHU  = 4'b1011,
    MD_DIV    = 4'b1100,
    MD_DIVU   = 4'b1101,
    MD_REM    = 4'b1110,
    MD_REMU   = 4'b1111
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } md_state_e;

endpackage

// File: rtl/md_unit_if.sv
// rtl/md_unit_if.sv - request/response/flush channel between execute stage and md_unit
interface md_unit_if #(parameter int WIDTH = 32);

  logic             req_valid;
  logic             req_ready;
  logic [3:0]       req_op;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic             flush;
  logic             resp_valid;
  logic             resp_ready;
  logic [WIDTH-1:0] resp_data;

  modport master (
    output req_valid, req_op, req_a, req_b, flush, resp_ready,
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, flush, resp_ready,
    output req_ready, resp_valid, resp_data
  );

endinterface

// File: rtl/md_result_fix.sv
// rtl/md_result_fix.sv - applies sign correction to magnitude results and selects the op's result
module md_result_fix
  import md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  md_op_e             i_op,
  input  logic [2*WIDTH-1:0] i_prod,
  input  logic [WIDTH-1:0]   i_quot,
  input  logic [WIDTH-1:0]   i_rem,
  input  logic               i_sign_a,
  input  logic               i_sign_b,
  output logic [WIDTH-1:0]   o_result
);

  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quot_fix;
  logic [WIDTH-1:0]   w_rem_fix;

  // Remainder follows the dividend; product and quotient follow the sign product.
  always_comb begin
    w_prod_fix = (i_sign_a ^ i_sign_b) ? -i_prod : i_prod;
    w_quot_fix = (i_sign_a ^ i_sign_b) ? -i_quot : i_quot;
    w_rem_fix  = i_sign_a ? -i_rem : i_rem;
    o_result   = w_rem_fix;
    case (i_op)
      MD_MUL:                        o_result = w_prod_fix[WIDTH-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU:  o_result = w_prod_fix[2*WIDTH-1:WIDTH];
      MD_DIV, MD_DIVU:               o_result = w_quot_fix;
      default:                       o_result = w_rem_fix;
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// rtl/md_unit.sv - iterative RV32M multiply/divide unit with shared shift/add-subtract datapath
module md_unit
  import md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst,
  md_unit_if.slave bus
);

  md_state_e             r_state;
  md_op_e                r_op;
  logic [MD_CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]      r_acc;
  logic [WIDTH-1:0]      r_lo;
  logic [WIDTH-1:0]      r_mcand;
  logic [WIDTH-1:0]      r_resp_data;
  logic                  r_sign_a;
  logic                  r_sign_b;

  md_op_e                w_in_op;
  logic                  w_accept;
  logic                  w_a_signed;
  logic                  w_b_signed;
  logic                  w_sa;
  logic                  w_sb;
  logic [WIDTH-1:0]      w_a_mag;
  logic [WIDTH-1:0]      w_b_mag;
  logic                  w_in_div;
  logic                  w_div_zero;
  logic                  w_div_ovf;

  assign w_in_op    = md_op_e'(bus.req_op);
  assign w_accept   = (r_state == IDLE) && bus.req_valid && bus.req_op[3];
  assign w_a_signed = (w_in_op == MD_MUL) || (w_in_op == MD_MULH) || (w_in_op == MD_MULHSU) ||
                      (w_in_op == MD_DIV) || (w_in_op == MD_REM);
  assign w_b_signed = (w_in_op == MD_MUL) || (w_in_op == MD_MULH) ||
                      (w_in_op == MD_DIV) || (w_in_op == MD_REM);
  assign w_sa       = w_a_signed & bus.req_a[WIDTH-1];
  assign w_sb       = w_b_signed & bus.req_b[WIDTH-1];
  assign w_a_mag    = w_sa ? -bus.req_a : bus.req_a;
  assign w_b_mag    = w_sb ? -bus.req_b : bus.req_b;
  assign w_in_div   = bus.req_op[2];
  assign w_div_zero = w_in_div && (bus.req_b == '0);
  assign w_div_ovf  = ((w_in_op == MD_DIV) || (w_in_op == MD_REM)) &&
                      (bus.req_a == {1'b1, {(WIDTH-1){1'b0}}}) && (bus.req_b == '1);

  // One adder: accumulate for multiply, trial-subtract (a + ~b + 1) for divide.
  logic                  w_div;
  logic [WIDTH:0]        w_shift;
  logic [WIDTH:0]        w_opa;
  logic [WIDTH:0]        w_opb;
  logic [WIDTH:0]        w_sum;
  logic [WIDTH-1:0]      w_acc_nxt;
  logic [WIDTH-1:0]      w_lo_nxt;
  logic [WIDTH-1:0]      w_result;

  assign w_div     = r_op[2];
  assign w_shift   = {r_acc, r_lo[WIDTH-1]};
  assign w_opa     = w_div ? w_shift : {1'b0, r_acc};
  assign w_opb     = w_div ? ~{1'b0, r_mcand} : (r_lo[0] ? {1'b0, r_mcand} : '0);
  assign w_sum     = w_opa + w_opb + {{WIDTH{1'b0}}, w_div};
  assign w_acc_nxt = w_div ? (w_sum[WIDTH] ? w_shift[WIDTH-1:0] : w_sum[WIDTH-1:0])
                           : w_sum[WIDTH:1];
  assign w_lo_nxt  = w_div ? {r_lo[WIDTH-2:0], ~w_sum[WIDTH]}
                           : {w_sum[0], r_lo[WIDTH-1:1]};

  md_result_fix #(.WIDTH(WIDTH)) u_fix (
    .i_op     (r_op),
    .i_prod   ({w_acc_nxt, w_lo_nxt}),
    .i_quot   (w_lo_nxt),
    .i_rem    (w_acc_nxt),
    .i_sign_a (r_sign_a),
    .i_sign_b (r_sign_b),
    .o_result (w_result)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_op        <= MD_MUL;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_lo        <= '0;
      r_mcand     <= '0;
      r_resp_data <= '0;
      r_sign_a    <= 1'b0;
      r_sign_b    <= 1'b0;
    end else if (bus.flush) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_op     <= w_in_op;
            r_sign_a <= w_sa;
            r_sign_b <= w_sb;
            r_acc    <= '0;
            r_cnt    <= MD_CNT_W'(MD_ITER - 1);
            // Multiply shifts the multiplier (b) out of r_lo; divide shifts the dividend (a) out.
            r_lo     <= w_in_div ? w_a_mag : w_b_mag;
            r_mcand  <= w_in_div ? w_b_mag : w_a_mag;
            if (w_div_zero) begin
              r_resp_data <= bus.req_op[1] ? bus.req_a : '1;
              r_state     <= DONE;
            end else if (w_div_ovf) begin
              r_resp_data <= bus.req_op[1] ? '0 : {1'b1, {(WIDTH-1){1'b0}}};
              r_state     <= DONE;
            end else begin
              r_state <= CALC;
            end
          end
        end
        CALC: begin
          r_acc <= w_acc_nxt;
          r_lo  <= w_lo_nxt;
          r_cnt <= r_cnt - MD_CNT_W'(1);
          if (r_cnt == '0) begin
            r_resp_data <= w_result;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (bus.resp_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = (r_state == IDLE);
  assign bus.resp_valid = (r_state == DONE);
  assign bus.resp_data  = r_resp_data;

endmodule

// File: tb/tb_md_unit.sv
// tb/tb_md_unit.sv - self-checking bench for md_unit against an arithmetic reference model
module tb_md_unit;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  md_unit_if #(.WIDTH(32)) bus ();

  md_unit #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_md(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      p;
    logic [63:0] u;
    int          ia;
    int          ib;
    logic        ovf;
    ia  = a;
    ib  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      4'b1000: begin p = longint'(ia) * longint'(ib); u = p; return u[31:0]; end
      4'b1001: begin p = longint'(ia) * longint'(ib); u = p; return u[63:32]; end
      4'b1010: begin p = longint'(ia) * longint'({32'b0, b}); u = p; return u[63:32]; end
      4'b1011: begin u = {32'b0, a} * {32'b0, b}; return u[63:32]; end
      4'b1100: return (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : 32'(ia / ib));
      4'b1101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'b1110: return (b == 0) ? a : (ovf ? 32'd0 : 32'(ia % ib));
      4'b1111: return (b == 0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int ref_lat(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic is_div;
    logic signed_div;
    is_div     = op[2];
    signed_div = (op == 4'b1100) || (op == 4'b1110);
    if (is_div && (b == 0)) return 1;
    if (signed_div && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) return 1;
    return 33;
  endfunction

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, output bit ok);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    ok            = bus.req_ready;
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_resp(output int lat, output bit ok);
    lat = 1;
    while (!bus.resp_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    ok = bus.resp_valid;
  endtask

  task automatic ack();
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0;
  endtask

  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] data, output int lat, output bit ok);
    bit ok_req;
    bit ok_resp;
    issue(op, a, b, ok_req);
    wait_resp(lat, ok_resp);
    data = bus.resp_data;
    ok   = ok_req && ok_resp;
    if (ok_resp) ack();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0 || bus.resp_data !== 32'd0) begin
      failures++;
      $display("FAIL reset: ready=%b valid=%b data=%h want ready=1 valid=0 data=0",
               bus.req_ready, bus.resp_valid, bus.resp_data);
    end
    rst = 1'b0;
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
    string       name;
  } vec_t;

  task automatic test_directed();
    vec_t        vecs[13];
    logic [31:0] data;
    int          lat;
    bit          ok;
    vecs = '{
      '{4'b1000, 32'd7,          32'd6,          32'd42,         33, "mul_7x6"},
      '{4'b1001, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0000,  33, "mulh_m1xm1"},
      '{4'b1011, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  33, "mulhu_max"},
      '{4'b1010, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFF,  33, "mulhsu_m1x2"},
      '{4'b1000, 32'h8000_0000,  32'd2,          32'd0,          33, "mul_min_x2"},
      '{4'b1100, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  33, "div_m7_2"},
      '{4'b1110, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  33, "rem_m7_2"},
      '{4'b1101, 32'd100,        32'd7,          32'd14,         33, "divu_100_7"},
      '{4'b1111, 32'd100,        32'd7,          32'd2,          33, "remu_100_7"},
      '{4'b1101, 32'd5,          32'd0,          32'hFFFF_FFFF,  1,  "divu_by0"},
      '{4'b1110, 32'd5,          32'd0,          32'd5,          1,  "rem_by0"},
      '{4'b1100, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1,  "div_ovf"},
      '{4'b1110, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1,  "rem_ovf"}
    };
    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, data, lat, ok);
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL %s timeout: no handshake within bound", vecs[i].name);
      end
      checks++;
      if (data !== vecs[i].exp) begin
        failures++;
        $display("FAIL %s data: got %h want %h", vecs[i].name, data, vecs[i].exp);
      end
      checks++;
      if (lat !== vecs[i].lat) begin
        failures++;
        $display("FAIL %s latency: got %0d want %0d", vecs[i].name, lat, vecs[i].lat);
      end
    end
  endtask

  task automatic test_random();
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] data;
    int          lat;
    bit          ok;
    for (int i = 0; i < 40; i++) begin
      op = {1'b1, 3'($urandom_range(0, 7))};
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 9))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 15));
        3: begin a = -32'($urandom_range(0, 1000)); b = -32'($urandom_range(1, 20)); end
        default: ;
      endcase
      run_op(op, a, b, data, lat, ok);
      checks++;
      if (!ok || data !== ref_md(op, a, b) || lat !== ref_lat(op, a, b)) begin
        failures++;
        $display("FAIL random[%0d] op=%b a=%h b=%h: got data=%h lat=%0d ok=%b want data=%h lat=%0d",
                 i, op, a, b, data, lat, ok, ref_md(op, a, b), ref_lat(op, a, b));
      end
    end
  endtask

  task automatic test_invalid_op();
    logic [31:0] data;
    int          lat;
    bit          ok;
    bit          bad;
    bad = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = {1'b0, 3'($urandom_range(0, 7))};
    bus.req_a     = 32'd3;
    bus.req_b     = 32'd4;
    repeat (4) begin
      @(negedge clk);
      if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) bad = 1'b1;
    end
    bus.req_valid = 1'b0;
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL invalid_op: got accepted or response, want ignored and idle");
    end
    run_op(4'b1000, 32'd3, 32'd5, data, lat, ok);
    checks++;
    if (!ok || data !== 32'd15 || lat !== 33) begin
      failures++;
      $display("FAIL invalid_op_follow: got data=%h lat=%0d ok=%b want data=0000000f lat=33", data, lat, ok);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hold;
    int          lat;
    bit          ok;
    bit          ok2;
    bit          bad;
    a = $urandom;
    b = $urandom;
    issue(4'b1001, a, b, ok);
    wait_resp(lat, ok2);
    hold = bus.resp_data;
    checks++;
    if (!ok || !ok2 || hold !== ref_md(4'b1001, a, b)) begin
      failures++;
      $display("FAIL bp_data: got %h ok=%b/%b want %h", hold, ok, ok2, ref_md(4'b1001, a, b));
    end
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.resp_data !== hold || bus.req_ready !== 1'b0 || bus.resp_valid !== 1'b1) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL bp_hold: data/ready/valid changed while stalled, want data=%h ready=0 valid=1", hold);
    end
    ack();
    checks++;
    if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0 || bus.resp_data !== hold) begin
      failures++;
      $display("FAIL bp_release: got ready=%b valid=%b data=%h want ready=1 valid=0 data=%h",
               bus.req_ready, bus.resp_valid, bus.resp_data, hold);
    end
    bus.req_valid = 1'b1;
    bus.req_op    = 4'b1101;
    bus.req_a     = 32'd100;
    bus.req_b     = 32'd7;
    @(negedge clk);
    bus.req_valid = 1'b0;
    checks++;
    if (bus.req_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_next_accept: got ready=%b want 0 (request taken)", bus.req_ready);
    end
    wait_resp(lat, ok);
    checks++;
    if (!ok || bus.resp_data !== 32'd14 || lat !== 33) begin
      failures++;
      $display("FAIL bp_next_result: got data=%h lat=%0d want 0000000e lat=33", bus.resp_data, lat);
    end
    if (ok) ack();
  endtask

  task automatic test_abort(input bit use_rst, input int at_cycle);
    logic [31:0] data;
    int          lat;
    bit          ok;
    bit          seen;
    issue(4'b1101, $urandom, 32'($urandom_range(1, 1000)), ok);
    seen = 1'b0;
    repeat (at_cycle - 1) begin
      if (bus.resp_valid) seen = 1'b1;
      @(negedge clk);
    end
    if (use_rst) rst = 1'b1;
    else         bus.flush = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_op    = 4'b1000;
    bus.req_a     = 32'd2;
    bus.req_b     = 32'd2;
    @(negedge clk);
    rst           = 1'b0;
    bus.flush     = 1'b0;
    bus.req_valid = 1'b0;
    checks++;
    if (!ok || bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin
      failures++;
      $display("FAIL abort_%s_idle: got ready=%b valid=%b want ready=1 valid=0",
               use_rst ? "rst" : "flush", bus.req_ready, bus.resp_valid);
    end
    if (use_rst) begin
      checks++;
      if (bus.resp_data !== 32'd0) begin
        failures++;
        $display("FAIL abort_rst_data: got %h want 00000000", bus.resp_data);
      end
    end
    repeat (40) begin
      @(negedge clk);
      if (bus.resp_valid || !bus.req_ready) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL abort_%s_quiet: got a response or busy state, want none", use_rst ? "rst" : "flush");
    end
    run_op(4'b1000, 32'd3, 32'd3, data, lat, ok);
    checks++;
    if (!ok || data !== 32'd9 || lat !== 33) begin
      failures++;
      $display("FAIL abort_%s_follow: got data=%h lat=%0d want 00000009 lat=33",
               use_rst ? "rst" : "flush", data, lat);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time bound");
    $fatal(1);
  end

  initial begin
    rst            = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_op     = 4'b0000;
    bus.req_a      = 32'd0;
    bus.req_b      = 32'd0;
    bus.flush      = 1'b0;
    bus.resp_ready = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_invalid_op();
    test_backpressure();
    test_abort(1'b0, 10);
    test_abort(1'b1, 20);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
